if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  PC register and I-cache fetch sequencer; consumes CTRL's ctrl_signal_pc / ctrl_to_pc_new outputs and produces CTRL's icache_data_valid input.
//  Issues one-outstanding valid/ready fetch requests, holds returned instruction for IF/ID, redirects on CTRL_STATE_Branch.
//  Sits between CTRL, the I-cache and the IF/ID pipeline register.
// PARAMETERS
//  RESET_PC  64'h0000_0000_8000_0000  PC loaded on reset
//  ADDR_W    64                        PC/address width (matches `AddrBus)
//  INST_W    32                        instruction width
// PORTS
//  clk                 in   1       clock, rising edge
//  rst                 in   1       asynchronous, active-low reset
//  ctrl_signal_pc_i    in   2       `CTRL_STATE_Default/Stalled/Bubble/Branch from CTRL
//  ctrl_to_pc_new_i    in   ADDR_W  redirect target, sampled when ctrl_signal_pc_i==Branch
//  icache_req_valid_o  out  1       fetch request valid
//  icache_req_addr_o   out  ADDR_W  fetch address (= current PC)
//  icache_req_ready_i  in   1       I-cache accepts request
//  icache_resp_valid_i in   1       response valid (one per accepted request, any later cycle)
//  icache_resp_data_i  in   INST_W  fetched instruction
//  icache_data_valid_o out  1       to CTRL: if_valid_o
//  if_pc_o             out  ADDR_W  PC of held instruction
//  if_inst_o           out  INST_W  held instruction
//  if_valid_o          out  1       if_pc_o/if_inst_o valid for IF/ID
// BEHAVIOUR
//  Reset (rst==0, async): pc=RESET_PC, state=REQ, req_valid=0, if_valid=0, if_pc=0, if_inst=0, stale=0.
//  States: REQ (drive request), WAIT (request accepted, awaiting response), HOLD (instruction held), FLUSH (wait to drop stale response).
//  req_valid_o=1 only in REQ and ctrl!=Stalled; req_addr_o=pc; addr stable while valid&&!ready.
//  REQ: valid&&ready -> WAIT. WAIT: resp_valid -> capture {pc,data}, if_valid=1 next cycle, -> HOLD.
//  HOLD, ctrl==Default or Bubble: pc<=pc+4, if_valid<=0, -> REQ (one output per fetch; no duplicate delivery).
//  HOLD, ctrl==Stalled: outputs and pc held unchanged.
//  Branch (any state): pc<=ctrl_to_pc_new_i, if_valid<=0 next cycle; from REQ/HOLD -> REQ; from WAIT with no
//   resp same cycle -> FLUSH; from WAIT with resp same cycle -> response discarded, -> REQ.
//  FLUSH: req_valid=0; on resp_valid discard data -> REQ. Further Branch in FLUSH updates pc only.
//  Branch has priority over Stalled/Default; response arriving with Branch is never delivered.
//  Stalled in REQ: req_valid=0 (request withdrawn only before acceptance); Stalled in WAIT: response still captured.
//  pc+4 wraps modulo 2^ADDR_W, no flag. Fetch latency: min 2 cycles REQ->if_valid with 0-wait cache.
//  Mid-operation reset: outstanding response after reset release is ignored (state REQ treats resp_valid as don't-care).
//  icache_data_valid_o == if_valid_o (combinational).
// CONFIGURATION
//  FETCH_MISALIGN_CHK_EN defined: adds output if_misalign_o (1 bit, reset 0). If pc[1:0]!=0 in REQ, no request
//   is issued; if_misalign_o=1, if_valid=1, if_inst=32'h0000_0013 (nop), -> HOLD; cleared on leaving HOLD.
//  Not defined: port absent; pc[1:0] ignored, request issued with pc as-is.
// TESTING
//  Reset release, ready=1, resp 1 cycle later, data 32'h00A00093 -> req_addr 0x80000000, if_valid=1 with if_pc=0x80000000, next req 0x80000004.
//  ready held 0 for 3 cycles -> req_valid stays 1, req_addr constant, no pc advance.
//  Branch to 0x80001000 while in WAIT, resp arrives 2 cycles later with 32'hDEADBEEF -> data dropped, next req addr 0x80001000, if_valid never 1 for DEADBEEF.
//  Stalled for 4 cycles in HOLD -> if_pc/if_inst/if_valid unchanged, req_valid=0; release -> req pc+4.
//  pc=64'hFFFF_FFFF_FFFF_FFFC advance -> next req_addr 0.
//  rst asserted in WAIT -> outputs immediately reset values; late resp_valid after release not delivered.
//  FETCH_MISALIGN_CHK_EN: Branch to 0x80000002 -> no request, if_misalign_o=1, if_inst=32'h00000013.

Source files
------------

// File: rtl/if_fetch_unit.sv
// PC register and I-cache fetch sequencer: one outstanding valid/ready request, holds the
// returned instruction for IF/ID. Optional misalign trap enabled by FETCH_MISALIGN_CHK_EN.
module if_fetch_unit #(
   parameter int unsigned       ADDR_W   = 64,
   parameter int unsigned       INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h0000_0000_8000_0000)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        ctrl_signal_pc_i,
   input  logic [ADDR_W-1:0] ctrl_to_pc_new_i,
   output logic              icache_req_valid_o,
   output logic [ADDR_W-1:0] icache_req_addr_o,
   input  logic              icache_req_ready_i,
   input  logic              icache_resp_valid_i,
   input  logic [INST_W-1:0] icache_resp_data_i,
   output logic              icache_data_valid_o,
   output logic [ADDR_W-1:0] if_pc_o,
   output logic [INST_W-1:0] if_inst_o,
   output logic              if_valid_o
`ifdef FETCH_MISALIGN_CHK_EN
   ,
   output logic              if_misalign_o
`endif
);

   localparam logic [1:0] CTRL_DEFAULT = 2'b00;
   localparam logic [1:0] CTRL_STALLED = 2'b01;
   localparam logic [1:0] CTRL_BUBBLE  = 2'b10;
   localparam logic [1:0] CTRL_BRANCH  = 2'b11;

   localparam logic [1:0] ST_REQ   = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_FLUSH = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] if_pc_q, if_pc_d;
   logic [INST_W-1:0] if_inst_q, if_inst_d;
   logic              if_valid_q, if_valid_d;
   logic              is_branch, is_stalled, is_advance;
   logic              misaligned;
   logic              req_fire;

   assign is_branch  = (ctrl_signal_pc_i == CTRL_BRANCH);
   assign is_stalled = (ctrl_signal_pc_i == CTRL_STALLED);
   assign is_advance = (ctrl_signal_pc_i == CTRL_DEFAULT) || (ctrl_signal_pc_i == CTRL_BUBBLE);

`ifdef FETCH_MISALIGN_CHK_EN
   logic misalign_q, misalign_d;
   assign misaligned    = (pc_q[1:0] != 2'b00);
   assign if_misalign_o = misalign_q;
`else
   assign misaligned = 1'b0;
`endif

   // A branch in REQ retargets the PC, so no request is offered for the stale address.
   assign icache_req_valid_o = rst && (state_q == ST_REQ) && !is_stalled && !is_branch &&
                               !misaligned;
   assign icache_req_addr_o  = pc_q;
   assign req_fire           = icache_req_valid_o && icache_req_ready_i;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      if_valid_d = if_valid_q;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_d = misalign_q;
`endif
      if (is_branch) begin
         pc_d       = ctrl_to_pc_new_i;
         if_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
         misalign_d = 1'b0;
`endif
         unique case (state_q)
            ST_WAIT:  state_d = icache_resp_valid_i ? ST_REQ : ST_FLUSH;
            ST_FLUSH: state_d = icache_resp_valid_i ? ST_REQ : ST_FLUSH;
            default:  state_d = ST_REQ;
         endcase
      end else begin
         unique case (state_q)
            ST_REQ: begin
               if (misaligned && !is_stalled) begin
`ifdef FETCH_MISALIGN_CHK_EN
                  misalign_d = 1'b1;
                  if_inst_d  = INST_W'(32'h0000_0013);
                  if_pc_d    = pc_q;
                  if_valid_d = 1'b1;
                  state_d    = ST_HOLD;
`endif
               end else if (req_fire) begin
                  state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               // Responses are captured even while stalled; HOLD keeps them until released.
               if (icache_resp_valid_i) begin
                  if_pc_d    = pc_q;
                  if_inst_d  = icache_resp_data_i;
                  if_valid_d = 1'b1;
                  state_d    = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (is_advance) begin
                  pc_d       = pc_q + ADDR_W'(4);
                  if_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
                  misalign_d = 1'b0;
`endif
                  state_d    = ST_REQ;
               end
            end
            ST_FLUSH: begin
               if (icache_resp_valid_i) begin
                  state_d = ST_REQ;
               end
            end
            default: state_d = ST_REQ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_REQ;
         pc_q       <= RESET_PC;
         if_pc_q    <= '0;
         if_inst_q  <= '0;
         if_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
         if_valid_q <= if_valid_d;
      end
   end

`ifdef FETCH_MISALIGN_CHK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end
`endif

   assign if_pc_o             = if_pc_q;
   assign if_inst_o           = if_inst_q;
   assign if_valid_o          = if_valid_q;
   assign icache_data_valid_o = if_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: expected request addresses and deliveries are queued
// by the stimulus and popped by a monitor on each handshake / new delivery.
module tb_if_fetch_unit;

   localparam logic [1:0] CTRL_DEFAULT = 2'b00;
   localparam logic [1:0] CTRL_STALLED = 2'b01;
   localparam logic [1:0] CTRL_BRANCH  = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  ctrl_signal_pc_i;
   logic [63:0] ctrl_to_pc_new_i;
   logic        icache_req_valid_o;
   logic [63:0] icache_req_addr_o;
   logic        icache_req_ready_i;
   logic        icache_resp_valid_i;
   logic [31:0] icache_resp_data_i;
   logic        icache_data_valid_o;
   logic [63:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic        if_valid_o;
`ifdef FETCH_MISALIGN_CHK_EN
   logic        if_misalign_o;
`endif

   int vectors     = 0;
   int miscompares = 0;

   logic [63:0] exp_req_q[$];
   logic [95:0] exp_out_q[$];
   logic        prev_valid = 1'b0;

   if_fetch_unit dut (
      .clk                 (clk),
      .rst                 (rst),
      .ctrl_signal_pc_i    (ctrl_signal_pc_i),
      .ctrl_to_pc_new_i    (ctrl_to_pc_new_i),
      .icache_req_valid_o  (icache_req_valid_o),
      .icache_req_addr_o   (icache_req_addr_o),
      .icache_req_ready_i  (icache_req_ready_i),
      .icache_resp_valid_i (icache_resp_valid_i),
      .icache_resp_data_i  (icache_resp_data_i),
      .icache_data_valid_o (icache_data_valid_o),
      .if_pc_o             (if_pc_o),
      .if_inst_o           (if_inst_o),
      .if_valid_o          (if_valid_o)
`ifdef FETCH_MISALIGN_CHK_EN
      ,
      .if_misalign_o       (if_misalign_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Precondition: just after a rising edge with the DUT in REQ at address addr.
   task automatic fetch(input logic [63:0] addr, input logic [31:0] data, input int rd,
                        input int wd);
      exp_req_q.push_back(addr);
      exp_out_q.push_back({addr, data});
      icache_req_ready_i = 1'b0;
      for (int i = 0; i < rd; i++) begin
         @(negedge clk);
         check("req_valid_held", 64'(icache_req_valid_o), 64'd1);
         check("req_addr_held", icache_req_addr_o, addr);
         cyc();
      end
      icache_req_ready_i = 1'b1;
      cyc();
      icache_req_ready_i = 1'b0;
      repeat (wd) cyc();
      icache_resp_valid_i = 1'b1;
      icache_resp_data_i  = data;
      cyc();
      icache_resp_valid_i = 1'b0;
   endtask

   // Monitor: pops expectations on accepted requests and on each new delivery.
   always @(negedge clk) begin
      logic [63:0] ea;
      logic [95:0] eo;
      if (!rst) begin
         prev_valid = 1'b0;
      end else begin
         if (icache_req_valid_o && icache_req_ready_i) begin
            if (exp_req_q.size() == 0) begin
               check("unexpected_req", icache_req_addr_o, 64'hx);
            end else begin
               ea = exp_req_q.pop_front();
               check("req_addr", icache_req_addr_o, ea);
            end
         end
         if (if_valid_o && !prev_valid) begin
            if (exp_out_q.size() == 0) begin
               check("unexpected_delivery", {32'h0, if_inst_o}, 64'hx);
            end else begin
               eo = exp_out_q.pop_front();
               check("if_pc", if_pc_o, eo[95:32]);
               check("if_inst", {32'h0, if_inst_o}, {32'h0, eo[31:0]});
               check("data_valid", 64'(icache_data_valid_o), 64'd1);
            end
         end
         prev_valid = if_valid_o;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst                 = 1'b0;
      ctrl_signal_pc_i    = CTRL_DEFAULT;
      ctrl_to_pc_new_i    = '0;
      icache_req_ready_i  = 1'b0;
      icache_resp_valid_i = 1'b0;
      icache_resp_data_i  = '0;
      cyc();
      cyc();
      check("rst_req_valid", 64'(icache_req_valid_o), 64'd0);
      check("rst_if_valid", 64'(if_valid_o), 64'd0);
      check("rst_if_pc", if_pc_o, 64'd0);
      check("rst_if_inst", {32'h0, if_inst_o}, 64'd0);
      check("rst_data_valid", 64'(icache_data_valid_o), 64'd0);
      rst = 1'b1;

      // Basic fetch, then a fetch with 3 cycles of backpressure.
      fetch(64'h8000_0000, 32'h00A0_0093, 0, 0);
      cyc();
      fetch(64'h8000_0004, 32'h0010_8113, 3, 1);
      cyc();

      // Branch while waiting; late response must be dropped.
      exp_req_q.push_back(64'h8000_0008);
      icache_req_ready_i = 1'b1;
      cyc();
      icache_req_ready_i = 1'b0;
      ctrl_signal_pc_i   = CTRL_BRANCH;
      ctrl_to_pc_new_i   = 64'h8000_1000;
      cyc();
      ctrl_signal_pc_i = CTRL_DEFAULT;
      @(negedge clk);
      check("flush_no_req", 64'(icache_req_valid_o), 64'd0);
      cyc();
      icache_resp_valid_i = 1'b1;
      icache_resp_data_i  = 32'hDEAD_BEEF;
      cyc();
      icache_resp_valid_i = 1'b0;
      fetch(64'h8000_1000, 32'h0031_0193, 0, 2);

      // Stall in HOLD for 4 cycles.
      ctrl_signal_pc_i = CTRL_STALLED;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_if_valid", 64'(if_valid_o), 64'd1);
         check("stall_if_pc", if_pc_o, 64'h8000_1000);
         check("stall_if_inst", {32'h0, if_inst_o}, 64'h0031_0193);
         check("stall_req_valid", 64'(icache_req_valid_o), 64'd0);
         cyc();
      end
      ctrl_signal_pc_i = CTRL_DEFAULT;
      cyc();
      fetch(64'h8000_1004, 32'h0041_8213, 0, 0);
      cyc();

      // PC wrap.
      ctrl_signal_pc_i = CTRL_BRANCH;
      ctrl_to_pc_new_i = 64'hFFFF_FFFF_FFFF_FFFC;
      cyc();
      ctrl_signal_pc_i = CTRL_DEFAULT;
      fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h0052_0293, 0, 0);
      cyc();
      fetch(64'h0, 32'h0062_8313, 0, 1);
      cyc();

      // Branch in WAIT with the response in the same cycle: response discarded.
      exp_req_q.push_back(64'h4);
      icache_req_ready_i = 1'b1;
      cyc();
      icache_req_ready_i  = 1'b0;
      ctrl_signal_pc_i    = CTRL_BRANCH;
      ctrl_to_pc_new_i    = 64'h8000_2000;
      icache_resp_valid_i = 1'b1;
      icache_resp_data_i  = 32'hBAD0_BAD0;
      cyc();
      icache_resp_valid_i = 1'b0;
      ctrl_signal_pc_i    = CTRL_DEFAULT;
      fetch(64'h8000_2000, 32'h0073_0393, 0, 0);

      // Branch out of HOLD.
      ctrl_signal_pc_i = CTRL_BRANCH;
      ctrl_to_pc_new_i = 64'h8000_3000;
      cyc();
      ctrl_signal_pc_i = CTRL_DEFAULT;
      @(negedge clk);
      check("branch_hold_if_valid", 64'(if_valid_o), 64'd0);
      cyc();

      // Reset while waiting; late response after release is ignored.
      exp_req_q.push_back(64'h8000_3000);
      icache_req_ready_i = 1'b1;
      cyc();
      icache_req_ready_i = 1'b0;
      rst = 1'b0;
      #1;
      check("mid_rst_req_valid", 64'(icache_req_valid_o), 64'd0);
      check("mid_rst_if_valid", 64'(if_valid_o), 64'd0);
      check("mid_rst_if_pc", if_pc_o, 64'd0);
      check("mid_rst_if_inst", {32'h0, if_inst_o}, 64'd0);
      cyc();
      rst                 = 1'b1;
      icache_resp_valid_i = 1'b1;
      icache_resp_data_i  = 32'hCAFE_F00D;
      cyc();
      icache_resp_valid_i = 1'b0;
      fetch(64'h8000_0000, 32'h0083_8413, 0, 0);
      cyc();

`ifdef FETCH_MISALIGN_CHK_EN
      ctrl_signal_pc_i = CTRL_BRANCH;
      ctrl_to_pc_new_i = 64'h8000_0002;
      cyc();
      ctrl_signal_pc_i = CTRL_DEFAULT;
      exp_out_q.push_back({64'h8000_0002, 32'h0000_0013});
      @(negedge clk);
      check("misalign_no_req", 64'(icache_req_valid_o), 64'd0);
      cyc();
      @(negedge clk);
      check("misalign_flag", 64'(if_misalign_o), 64'd1);
      ctrl_signal_pc_i = CTRL_BRANCH;
      ctrl_to_pc_new_i = 64'h8000_0100;
      cyc();
      ctrl_signal_pc_i = CTRL_DEFAULT;
      @(negedge clk);
      check("misalign_clear", 64'(if_misalign_o), 64'd0);
      cyc();
`endif

      repeat (3) cyc();
      check("req_queue_drained", 64'(exp_req_q.size()), 64'd0);
      check("out_queue_drained", 64'(exp_out_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
